// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates i-cache line fills and load/store requests onto the
// byte-serial memory unit. Optional IO store stall: MEM_ARB_IO_STALL_EN.
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    localparam int IDXW = $clog2(LINE_WORDS)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            rob_clear,
    input  logic            ic_valid,
    input  logic [31:0]     ic_addr,
    output logic            ic_word_valid,
    output logic [IDXW-1:0] ic_word_idx,
    output logic [31:0]     ic_word,
    output logic            ic_ready,
    input  logic            ls_valid,
    input  logic            ls_wr,
    input  logic [31:0]     ls_addr,
    input  logic [2:0]      ls_len,
    input  logic [31:0]     ls_wdata,
    output logic            ls_ready,
    output logic [31:0]     ls_rdata,
    output logic            mu_valid,
    output logic            mu_wr,
    output logic [31:0]     mu_addr,
    output logic [2:0]      mu_len,
    output logic [31:0]     mu_wdata,
    input  logic            mu_ready,
    input  logic [31:0]     mu_rdata,
    input  logic            io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IFETCH, DATA} state_t;

    localparam logic [31:0]     LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(LINE_WORDS - 1);

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic [IDXW-1:0] cnt_q, cnt_d;

    logic            mu_valid_d, mu_wr_d;
    logic [31:0]     mu_addr_d, mu_wdata_d;
    logic [2:0]      mu_len_d;
    logic            ic_word_valid_d, ic_ready_d;
    logic [IDXW-1:0] ic_word_idx_d;
    logic [31:0]     ic_word_d;
    logic            ls_ready_d;
    logic [31:0]     ls_rdata_d;

    logic ic_cand, ls_cand, grant_ic, grant_ls, mu_done;
    logic io_hold;

    // A port whose completion pulse is high cannot be re-granted this cycle
    assign ic_cand  = ic_valid & ~ic_ready;
    assign ls_cand  = ls_valid & ~ls_ready;
    // rr_q = 1 means the i-cache was granted last, so data wins a tie
    assign grant_ic = ic_cand & (~ls_cand | ~rr_q);
    assign grant_ls = ls_cand & ~grant_ic;
    assign mu_done  = mu_valid & mu_ready;

`ifdef MEM_ARB_IO_STALL_EN
    // Stores to the IO window must wait while the UART buffer is full
    assign io_hold = ls_wr & (ls_addr[17:16] == 2'b11) & io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign io_hold   = 1'b0;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        cnt_d           = cnt_q;
        mu_valid_d      = mu_valid;
        mu_wr_d         = mu_wr;
        mu_addr_d       = mu_addr;
        mu_len_d        = mu_len;
        mu_wdata_d      = mu_wdata;
        ic_word_valid_d = 1'b0;
        ic_ready_d      = 1'b0;
        ic_word_idx_d   = ic_word_idx;
        ic_word_d       = ic_word;
        ls_ready_d      = 1'b0;
        ls_rdata_d      = ls_rdata;
        if (rob_clear) begin
            state_d    = IDLE;
            mu_valid_d = 1'b0;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_ic) begin
                        state_d    = IFETCH;
                        rr_d       = 1'b1;
                        cnt_d      = '0;
                        mu_valid_d = 1'b1;
                        mu_wr_d    = 1'b0;
                        mu_addr_d  = ic_addr & LINE_MASK;
                        mu_len_d   = 3'b010;
                        mu_wdata_d = '0;
                    end else if (grant_ls) begin
                        state_d    = DATA;
                        rr_d       = 1'b0;
                        mu_valid_d = ~io_hold;
                        mu_wr_d    = ls_wr;
                        mu_addr_d  = ls_addr;
                        mu_len_d   = ls_len;
                        mu_wdata_d = ls_wdata;
                    end
                end
                IFETCH: begin
                    if (mu_done) begin
                        ic_word_valid_d = 1'b1;
                        ic_word_idx_d   = cnt_q;
                        ic_word_d       = mu_rdata;
                        if (cnt_q == LAST_IDX) begin
                            ic_ready_d = 1'b1;
                            mu_valid_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            mu_addr_d = mu_addr + 32'd4;
                            cnt_d     = cnt_q + IDXW'(1);
                        end
                    end
                end
                DATA: begin
                    if (mu_done) begin
                        ls_ready_d = 1'b1;
                        ls_rdata_d = mu_wr ? 32'd0 : mu_rdata;
                        mu_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else if (!mu_valid && !io_buffer_full) begin
                        mu_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    mu_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, frozen while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            rr_q          <= 1'b0;
            cnt_q         <= '0;
            mu_valid      <= 1'b0;
            mu_wr         <= 1'b0;
            mu_addr       <= '0;
            mu_len        <= '0;
            mu_wdata      <= '0;
            ic_word_valid <= 1'b0;
            ic_ready      <= 1'b0;
            ic_word_idx   <= '0;
            ic_word       <= '0;
            ls_ready      <= 1'b0;
            ls_rdata      <= '0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            mu_valid      <= mu_valid_d;
            mu_wr         <= mu_wr_d;
            mu_addr       <= mu_addr_d;
            mu_len        <= mu_len_d;
            mu_wdata      <= mu_wdata_d;
            ic_word_valid <= ic_word_valid_d;
            ic_ready      <= ic_ready_d;
            ic_word_idx   <= ic_word_idx_d;
            ic_word       <= ic_word_d;
            ls_ready      <= ls_ready_d;
            ls_rdata      <= ls_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model of line fills, data requests and arbitration.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int LW = 4;
    localparam int IW = $clog2(LW);

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          rob_clear = 1'b0;
    logic          ic_valid = 1'b0;
    logic [31:0]   ic_addr = '0;
    logic          ic_word_valid;
    logic [IW-1:0] ic_word_idx;
    logic [31:0]   ic_word;
    logic          ic_ready;
    logic          ls_valid = 1'b0;
    logic          ls_wr = 1'b0;
    logic [31:0]   ls_addr = '0;
    logic [2:0]    ls_len = '0;
    logic [31:0]   ls_wdata = '0;
    logic          ls_ready;
    logic [31:0]   ls_rdata;
    logic          mu_valid;
    logic          mu_wr;
    logic [31:0]   mu_addr;
    logic [2:0]    mu_len;
    logic [31:0]   mu_wdata;
    logic          mu_ready;
    logic [31:0]   mu_rdata;
    logic          io_buffer_full = 1'b0;

    int checks = 0;
    int errors = 0;

    // memory unit model: completes after mem_lat cycles of mu_valid
    int          mem_lat = 4;
    int          mem_cnt;
    logic        mem_force = 1'b0;
    logic [31:0] mem_force_val = '0;

    // arbitration model: 1 when the i-cache was granted last
    bit last_ic = 1'b0;

    mem_arbiter #(.LINE_WORDS(LW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_clear(rob_clear),
        .ic_valid(ic_valid), .ic_addr(ic_addr),
        .ic_word_valid(ic_word_valid), .ic_word_idx(ic_word_idx),
        .ic_word(ic_word), .ic_ready(ic_ready),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_addr(ls_addr),
        .ls_len(ls_len), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mu_valid(mu_valid), .mu_wr(mu_wr), .mu_addr(mu_addr),
        .mu_len(mu_len), .mu_wdata(mu_wdata),
        .mu_ready(mu_ready), .mu_rdata(mu_rdata),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) mem_cnt <= 0;
        else if (rdy_in) begin
            if (!mu_valid || mu_ready) mem_cnt <= 0;
            else mem_cnt <= mem_cnt + 1;
        end
    end

    assign mu_ready = mu_valid && (mem_cnt == mem_lat - 1);
    assign mu_rdata = mem_force ? mem_force_val : mu_addr + 32'hA000_0000;

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~(32'(LW * 4) - 32'd1);
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_in = 1'b0;
        ic_valid = 1'b0;
        ls_valid = 1'b0;
        rob_clear = 1'b0;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        step();
        rst_in = 1'b1;
        step();
        last_ic = 1'b0;
    endtask

    task automatic wait_pulse(input bit is_ic, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (is_ic ? ic_ready : ls_ready) begin
                seen = 1'b1;
                if (is_ic) ic_valid = 1'b0;
                else ls_valid = 1'b0;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_%s: no ready pulse within %0d cycles",
                     is_ic ? "ic" : "ls", bound);
        end
    endtask

    task automatic test_reset();
        bit bad = 1'b0;
        rst_in = 1'b0;
        step();
        checks++;
        if ({mu_valid, mu_wr, mu_addr, mu_len, mu_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mu: got %b %b %h %b %h required all 0",
                     mu_valid, mu_wr, mu_addr, mu_len, mu_wdata);
        end
        checks++;
        if ({ic_word_valid, ic_word_idx, ic_word, ic_ready,
             ls_ready, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_resp: got %b %0d %h %b %b %h required all 0",
                     ic_word_valid, ic_word_idx, ic_word, ic_ready,
                     ls_ready, ls_rdata);
        end
        rst_in = 1'b1;
        step();
        ic_addr = 32'h2000;
        ic_valid = 1'b1;
        repeat (6) step();
        checks++;
        if (mu_valid !== 1'b1 || ic_word !== 32'hA000_2000) begin
            errors++;
            $display("FAIL midfill_state: mu_valid=%b ic_word=%h required 1 a0002000",
                     mu_valid, ic_word);
        end
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({mu_valid, mu_addr, mu_len, ic_word_valid, ic_word,
             ic_word_idx, ic_ready, ls_ready, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL async_reset: mu_valid=%b mu_addr=%h ic_word=%h required 0",
                     mu_valid, mu_addr, ic_word);
        end
        ic_valid = 1'b0;
        step();
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mu_valid || ic_word_valid || ic_ready || ls_ready) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_idle: got activity required none");
        end
        last_ic = 1'b0;
    endtask

    task automatic test_line_fill();
        int  k = 0;
        int  ma = 0;
        bit  done = 1'b0;
        bit  gap = 1'b0;
        apply_reset();
        ic_addr = 32'h1007;
        ic_valid = 1'b1;
        for (int n = 1; n <= 40 && !done; n++) begin
            step();
            if (n <= 4 * LW && !mu_valid) gap = 1'b1;
            if (mu_valid && mu_ready) begin
                checks++;
                if (mu_addr !== 32'h1000 + 32'(4 * ma) ||
                    mu_len !== 3'b010 || mu_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_mu_req: addr=%h len=%b wr=%b required %h 010 0",
                             mu_addr, mu_len, mu_wr, 32'h1000 + 32'(4 * ma));
                end
                ma++;
            end
            if (ic_word_valid) begin
                checks++;
                if (ic_word_idx !== IW'(k) ||
                    ic_word !== 32'hA000_1000 + 32'(4 * k) ||
                    ic_ready !== 1'(k == LW - 1) ||
                    (k == 0 && n != 5)) begin
                    errors++;
                    $display("FAIL fill_word: idx=%0d word=%h rdy=%b cyc=%0d required idx=%0d word=%h",
                             ic_word_idx, ic_word, ic_ready, n, k,
                             32'hA000_1000 + 32'(4 * k));
                end
                k++;
            end
            if (ic_ready) begin
                done = 1'b1;
                ic_valid = 1'b0;
                checks++;
                if (n != 1 + 4 * LW) begin
                    errors++;
                    $display("FAIL fill_latency: ic_ready at cycle %0d required %0d",
                             n, 1 + 4 * LW);
                end
            end
        end
        checks++;
        if (!done || k != LW || ma != LW || gap) begin
            errors++;
            $display("FAIL fill_complete: done=%b words=%0d reqs=%0d gap=%b required 1 %0d %0d 0",
                     done, k, ma, gap, LW, LW);
        end
        last_ic = 1'b1;
        step();
        checks++;
        if (mu_valid !== 1'b0 || ic_word_valid !== 1'b0 || ic_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_regrant: mu_valid=%b word_valid=%b required 0 0",
                     mu_valid, ic_word_valid);
        end
    endtask

    task automatic test_arbitration();
        int done_n = 0;
        bit exp_ic;
        apply_reset();
        ic_addr = 32'h3000;
        ls_wr = 1'b0;
        ls_addr = 32'h40;
        ls_len = 3'b010;
        ic_valid = 1'b1;
        ls_valid = 1'b1;
        for (int i = 0; i < 400 && done_n < 4; i++) begin
            step();
            if (ic_ready || ls_ready) begin
                exp_ic = ~last_ic;
                checks++;
                if (ic_ready !== exp_ic || ls_ready !== ~exp_ic ||
                    mu_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL arb_order: ic_ready=%b ls_ready=%b mu_valid=%b required %b %b 0",
                             ic_ready, ls_ready, mu_valid, exp_ic, ~exp_ic);
                end
                last_ic = exp_ic;
                done_n++;
                if (done_n == 4) begin
                    ic_valid = 1'b0;
                    ls_valid = 1'b0;
                end
            end
        end
        checks++;
        if (done_n != 4) begin
            errors++;
            $display("FAIL arb_timeout: %0d completions required 4", done_n);
        end
        ic_addr = 32'h3100;
        ic_valid = 1'b1;
        wait_pulse(1'b1, 60);
        last_ic = 1'b1;
        step();
        step();
        ls_addr = 32'h44;
        ic_addr = 32'h3204;
        ic_valid = 1'b1;
        ls_valid = 1'b1;
        step();
        checks++;
        if (mu_valid !== 1'b1 ||
            mu_addr !== (last_ic ? ls_addr : line_base(ic_addr))) begin
            errors++;
            $display("FAIL arb_tie: mu_valid=%b mu_addr=%h required 1 %h",
                     mu_valid, mu_addr,
                     last_ic ? ls_addr : line_base(ic_addr));
        end
        wait_pulse(1'b0, 60);
        wait_pulse(1'b1, 60);
        last_ic = 1'b1;
    endtask

    task automatic test_load_store();
        bit hit = 1'b0;
        bit bad = 1'b0;
        mem_force = 1'b1;
        mem_force_val = 32'hFFFF_FF80;
        ls_wr = 1'b0;
        ls_addr = 32'h20;
        ls_len = 3'b000;
        ls_valid = 1'b1;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (mu_valid && mu_ready) hit = 1'b1;
        end
        checks++;
        if (!hit || mu_addr !== 32'h20 || mu_len !== 3'b000 || mu_wr !== 1'b0) begin
            errors++;
            $display("FAIL load_req: hit=%b addr=%h len=%b wr=%b required 1 00000020 000 0",
                     hit, mu_addr, mu_len, mu_wr);
        end
        step();
        mem_force = 1'b0;
        checks++;
        if (ls_ready !== 1'b1 || ls_rdata !== 32'hFFFF_FF80 || mu_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_resp: ready=%b rdata=%h mu_valid=%b required 1 ffffff80 0",
                     ls_ready, ls_rdata, mu_valid);
        end
        ls_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ls_ready || mu_valid) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL load_regrant: activity after completion required none");
        end
        hit = 1'b0;
        ls_wr = 1'b1;
        ls_addr = 32'h84;
        ls_len = 3'b010;
        ls_wdata = 32'hDEAD_BEEF;
        ls_valid = 1'b1;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (mu_valid && mu_ready) hit = 1'b1;
        end
        checks++;
        if (!hit || mu_wr !== 1'b1 || mu_wdata !== 32'hDEAD_BEEF ||
            mu_addr !== 32'h84) begin
            errors++;
            $display("FAIL store_req: hit=%b wr=%b wdata=%h addr=%h required 1 1 deadbeef 00000084",
                     hit, mu_wr, mu_wdata, mu_addr);
        end
        step();
        checks++;
        if (ls_ready !== 1'b1 || ls_rdata !== 32'd0) begin
            errors++;
            $display("FAIL store_resp: ready=%b rdata=%h required 1 00000000",
                     ls_ready, ls_rdata);
        end
        ls_valid = 1'b0;
        last_ic = 1'b0;
        step();
    endtask

    task automatic test_rob_clear();
        int rc = 0;
        int k = 0;
        bit hit = 1'b0;
        bit bad = 1'b0;
        bit done = 1'b0;
        ic_addr = 32'h5010;
        ic_valid = 1'b1;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            if (mu_valid && mu_ready) begin
                if (rc == 1) begin
                    rob_clear = 1'b1;
                    ic_valid = 1'b0;
                    hit = 1'b1;
                end
                rc++;
            end
        end
        last_ic = 1'b1;
        step();
        rob_clear = 1'b0;
        checks++;
        if (!hit || ic_word_valid !== 1'b0 || ic_ready !== 1'b0) begin
            errors++;
            $display("FAIL rob_pulse: hit=%b word_valid=%b ic_ready=%b required 1 0 0",
                     hit, ic_word_valid, ic_ready);
        end
        checks++;
        if (mu_valid !== 1'b0) begin
            errors++;
            $display("FAIL rob_mu_valid: got %b required 0", mu_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (mu_valid || ic_word_valid || ic_ready) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rob_idle: activity after flush required none");
        end
        ic_addr = 32'h6004;
        ic_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (ic_word_valid) begin
                checks++;
                if (ic_word_idx !== IW'(k) ||
                    ic_word !== 32'hA000_6000 + 32'(4 * k)) begin
                    errors++;
                    $display("FAIL rob_refill: idx=%0d word=%h required %0d %h",
                             ic_word_idx, ic_word, k, 32'hA000_6000 + 32'(4 * k));
                end
                k++;
            end
            if (ic_ready) begin
                done = 1'b1;
                ic_valid = 1'b0;
            end
        end
        checks++;
        if (!done || k != LW) begin
            errors++;
            $display("FAIL rob_refill_done: done=%b words=%0d required 1 %0d",
                     done, k, LW);
        end
        step();
    endtask

    task automatic test_io_stall();
        bit got = 1'b0;
        bit bad = 1'b0;
        io_buffer_full = 1'b1;
        ls_wr = 1'b1;
        ls_addr = 32'h30000;
        ls_len = 3'b010;
        ls_wdata = 32'h55;
        ls_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
`ifdef MEM_ARB_IO_STALL_EN
            if (mu_valid !== 1'b0) bad = 1'b1;
`else
            if (i == 1 && mu_valid !== 1'b1) bad = 1'b1;
`endif
            if (ls_ready) begin
                got = 1'b1;
                ls_valid = 1'b0;
            end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL io_stall_hold: mu_valid=%b during io_buffer_full", mu_valid);
        end
        io_buffer_full = 1'b0;
`ifdef MEM_ARB_IO_STALL_EN
        step();
        checks++;
        if (mu_valid !== 1'b1 || mu_addr !== 32'h30000) begin
            errors++;
            $display("FAIL io_stall_release: mu_valid=%b addr=%h required 1 00030000",
                     mu_valid, mu_addr);
        end
`endif
        if (!got) wait_pulse(1'b0, 40);
        checks++;
        if (ls_rdata !== 32'd0) begin
            errors++;
            $display("FAIL io_store_resp: rdata=%h required 00000000", ls_rdata);
        end
        last_ic = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [135+IW:0] snap;
        logic [31:0] exp;
        int  ic_idx = 0;
        int  ic_age = 0;
        int  ls_age = 0;
        int  n_fill = 0;
        int  n_ls = 0;
        bit  r;
        bit  abort = 1'b0;
        for (int seg = 0; seg < 3 && !abort; seg++) begin
            mem_lat = seg + 1;
            for (int cyc = 0; cyc < 1100 && !abort; cyc++) begin
                rdy_in = ($urandom_range(0, 9) != 0);
                if (cyc < 800 && !ic_valid && $urandom_range(0, 3) == 0) begin
                    ic_addr = $urandom;
                    ic_valid = 1'b1;
                    ic_idx = 0;
                    ic_age = 0;
                end
                if (cyc < 800 && !ls_valid && $urandom_range(0, 2) == 0) begin
                    ls_wr = 1'($urandom_range(0, 1));
                    ls_addr = $urandom;
                    ls_len = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
                    ls_wdata = $urandom;
                    ls_valid = 1'b1;
                    ls_age = 0;
                end
                snap = {ic_word_valid, ic_word_idx, ic_word, ic_ready, ls_ready,
                        ls_rdata, mu_valid, mu_wr, mu_addr, mu_len, mu_wdata};
                r = rdy_in;
                step();
                if (!r) begin
                    checks++;
                    if ({ic_word_valid, ic_word_idx, ic_word, ic_ready, ls_ready,
                         ls_rdata, mu_valid, mu_wr, mu_addr, mu_len,
                         mu_wdata} !== snap) begin
                        errors++;
                        $display("FAIL rnd_freeze: outputs changed with rdy_in low");
                    end
                    continue;
                end
                if (ic_word_valid) begin
                    exp = line_base(ic_addr) + 32'(4 * ic_idx) + 32'hA000_0000;
                    checks++;
                    if (!ic_valid || ic_word_idx !== IW'(ic_idx) ||
                        ic_word !== exp || ic_ready !== 1'(ic_idx == LW - 1)) begin
                        errors++;
                        $display("FAIL rnd_fill: idx=%0d word=%h rdy=%b required %0d %h %b",
                                 ic_word_idx, ic_word, ic_ready, ic_idx, exp,
                                 1'(ic_idx == LW - 1));
                    end
                    ic_idx++;
                    if (ic_ready) begin
                        ic_valid = 1'b0;
                        n_fill++;
                    end
                end else if (ic_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_ic_ready: ic_ready=1 without word required 0");
                end
                if (ls_ready) begin
                    exp = ls_wr ? 32'd0 : ls_addr + 32'hA000_0000;
                    checks++;
                    if (!ls_valid || ls_rdata !== exp) begin
                        errors++;
                        $display("FAIL rnd_data: valid=%b rdata=%h required 1 %h",
                                 ls_valid, ls_rdata, exp);
                    end
                    ls_valid = 1'b0;
                    n_ls++;
                end
                if (ic_valid) ic_age++;
                if (ls_valid) ls_age++;
                if (ic_age > 200 || ls_age > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_timeout: ic_age=%0d ls_age=%0d limit 200",
                             ic_age, ls_age);
                    abort = 1'b1;
                end
            end
            checks++;
            if (!abort && (ic_valid || ls_valid)) begin
                errors++;
                $display("FAIL rnd_drain: ic_valid=%b ls_valid=%b required 0 0",
                         ic_valid, ls_valid);
                abort = 1'b1;
            end
        end
        rdy_in = 1'b1;
        mem_lat = 4;
        checks++;
        if (n_fill == 0 || n_ls == 0) begin
            errors++;
            $display("FAIL rnd_progress: fills=%0d data=%0d required both nonzero",
                     n_fill, n_ls);
        end
    endtask

    initial begin
        test_reset();
        test_line_fill();
        test_arbitration();
        test_load_store();
        test_rob_clear();
        test_io_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
